// File: rtl/common_pkg.sv
// Project-wide shared constants used by datapath blocks.
package common_pkg;
  localparam int DEFAULT_D_W = 32;
endpackage

// File: rtl/mux.sv
// Generic N-way one-level data multiplexer indexed by a binary select.
module mux #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N-1:0][W-1:0]  din,
  output logic [W-1:0]         dout
);
  localparam int L = $clog2(N);

  always_comb begin
    dout = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == L'(k)) dout = din[k];
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last granted index and
// rotates only when the caller reports a completed transfer via advance.
module rr_arbiter #(
  parameter int N = 4,
  localparam int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant_oh,
  output logic [L-1:0] grant_idx
);
  localparam logic [L:0] N_EXT = (L+1)'(N);

  logic [L-1:0] last_q;
  logic [L:0]   cand;
  logic         found;

  // Scan offsets 1..N from last_q; one extra bit keeps the wrap exact for non-power-of-2 N.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last_q} + (L+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req[cand[L-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[L-1:0];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (found) grant_oh[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= L'(N-1);
    else if (advance) last_q <= grant_idx;
  end
endmodule

// File: rtl/arb_mux.sv
// N-to-1 round-robin arbitrating mux with valid/ready handshakes.
// ARB_MUX_OUTPUT_REG_EN adds a one-beat output register; undefined gives a zero-latency path.
module arb_mux import common_pkg::*; #(
  parameter int N = 4,
  parameter int W = DEFAULT_D_W,
  localparam int L = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        i_valid,
  input  logic [N-1:0][W-1:0] i_data,
  output logic [N-1:0]        i_ready,
  output logic                o_valid,
  output logic [W-1:0]        o_data,
  output logic [L-1:0]        o_sel,
  input  logic                o_ready
);
  logic [N-1:0] grant_oh;
  logic [L-1:0] grant_idx;
  logic [W-1:0] mux_data;
  logic         accept;
  logic         advance;

  rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (i_valid),
    .advance   (advance),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  mux #(.N(N), .W(W)) u_mux (
    .sel  (grant_idx),
    .din  (i_data),
    .dout (mux_data)
  );

  assign i_ready = grant_oh & {N{accept}};
  assign advance = |(i_valid & i_ready);

`ifdef ARB_MUX_OUTPUT_REG_EN
  logic         vld_q;
  logic [W-1:0] data_q;
  logic [L-1:0] sel_q;

  // Loading while the held beat drains keeps full throughput under continuous o_ready.
  assign accept = rst_n & (~vld_q | o_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
    end else if (advance) begin
      vld_q  <= 1'b1;
      data_q <= mux_data;
      sel_q  <= grant_idx;
    end else if (o_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign o_valid = vld_q & rst_n;
  assign o_data  = data_q;
  assign o_sel   = sel_q;
`else
  assign accept  = rst_n & o_ready;
  assign o_valid = rst_n & (|i_valid);
  assign o_data  = mux_data;
  assign o_sel   = grant_idx;
`endif
endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux (N=4, W=32); works with or without ARB_MUX_OUTPUT_REG_EN.
module tb_arb_mux;
  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 2;
`ifdef ARB_MUX_OUTPUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        i_valid;
  logic [N-1:0][W-1:0] i_data;
  logic [N-1:0]        i_ready;
  logic                o_valid;
  logic [W-1:0]        o_data;
  logic [L-1:0]        o_sel;
  logic                o_ready;

  arb_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_sel(o_sel), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int xfer_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: last granted channel, a one-slot holding buffer, and a FIFO of accepted beats.
  int           m_last = N-1;
  bit           m_have = 0;
  logic [W-1:0] m_qd = '0;
  int           m_qs = 0;
  int           sb_sel[$];
  logic [W-1:0] sb_data[$];
  int           log_sel[$];
  logic [W-1:0] log_data[$];
  int           log_cyc[$];

  int           g, es, ps;
  logic [N-1:0] er;
  logic         ev, can;
  logic [W-1:0] ed, pd;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_i_ready", i_ready, 0);
      chk("rst_o_valid", o_valid, 0);
      sb_sel.delete();
      sb_data.delete();
      m_last = N-1;
      m_have = 0;
      m_qd   = '0;
      m_qs   = 0;
    end else begin
      g = -1;
      for (int i = 1; i <= N; i++)
        if (g < 0 && i_valid[(m_last+i)%N]) g = (m_last+i)%N;
      if (LAT == 1) begin
        can = !m_have || o_ready;
        ev  = m_have;
        ed  = m_qd;
        es  = m_qs;
      end else begin
        can = o_ready;
        ev  = (g >= 0);
        ed  = (g >= 0) ? i_data[g] : '0;
        es  = (g >= 0) ? g : 0;
      end
      er = '0;
      if (g >= 0 && can) er[g] = 1'b1;
      chk("i_ready", i_ready, er);
      chk("o_valid", o_valid, ev);
      if (ev || LAT == 1) begin
        chk("o_sel", o_sel, es);
        chk("o_data", o_data, ed);
      end
      chk("onehot0_i_ready", $onehot0(i_ready), 1);
      chk("ready_implies_valid", i_ready & ~i_valid, 0);
      if (er != 0) begin
        sb_sel.push_back(g);
        sb_data.push_back(i_data[g]);
        xfer_cnt++;
      end
      if (ev && o_ready) begin
        log_sel.push_back(int'(o_sel));
        log_data.push_back(o_data);
        log_cyc.push_back(cyc);
        chk("sb_has_beat", sb_sel.size() != 0, 1);
        if (sb_sel.size() != 0) begin
          ps = sb_sel.pop_front();
          pd = sb_data.pop_front();
          chk("sb_sel", o_sel, ps);
          chk("sb_data", o_data, pd);
        end
      end
      if (er != 0) m_last = g;
      if (LAT == 1) begin
        if (er != 0) begin
          m_have = 1;
          m_qd   = i_data[g];
          m_qs   = g;
        end else if (o_ready) m_have = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_sel.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic chk_log(input string nm, input int idx, input int exp_sel);
    if (idx < log_sel.size()) chk(nm, log_sel[idx], exp_sel);
    else chk({nm, "_missing"}, log_sel.size(), idx+1);
  endtask

  int seq_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int xc0;

  initial begin
    rst_n = 1'b0; i_valid = '0; i_data = '0; o_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    #1;
    chk("reset_o_valid", o_valid, 0);
    chk("reset_i_ready", i_ready, 0);
`ifdef ARB_MUX_OUTPUT_REG_EN
    chk("reset_o_sel", o_sel, 0);
    chk("reset_o_data", o_data, 0);
`endif

    // All channels valid, continuous o_ready: strict rotation from channel 0.
    clear_log();
    for (int k = 0; k < N; k++) i_data[k] = 32'h1000_0000 + k;
    i_valid = 4'b1111; o_ready = 1'b1;
    tick(8);
    chk("rot_count", log_sel.size(), 8 - LAT);
    for (int i = 0; i < 6; i++) chk_log("rot_sel", i, seq_a[i]);
    if (log_data.size() > 0) chk("rot_first_data", log_data[0], 32'h1000_0000);
    if (log_cyc.size() > 0) chk("rot_first_cycle", log_cyc[log_cyc.size()-1] - log_cyc[0], log_cyc.size()-1);
    i_valid = '0;
    tick(2);

    // Single requester on channel 2 streams without bubbles.
    clear_log();
    for (int c = 0; c < 8; c++) begin
      i_valid = 4'b0100;
      i_data[2] = 32'hA5A5_0000 + c;
      tick(1);
    end
    i_valid = '0;
    tick(2);
    chk("single_count", log_sel.size(), 8);
    for (int i = 0; i < 8 && i < log_sel.size(); i++) begin
      chk("single_sel", log_sel[i], 2);
      chk("single_data", log_data[i], 32'hA5A5_0000 + i);
      chk("single_nogap", log_cyc[i] - log_cyc[0], i);
    end

    // Downstream stall with all valid, then resume.
    xc0 = xfer_cnt;
    i_valid = 4'b1111; o_ready = 1'b0;
    tick(5);
    chk("stall_pulses", xfer_cnt - xc0, LAT);
    chk("stall_o_valid", o_valid, 1);
    chk("stall_o_sel", o_sel, 3);
    clear_log();
    o_ready = 1'b1;
    tick(4);
    chk_log("resume_sel0", 0, 3);
    chk_log("resume_sel1", 1, 0);
    chk_log("resume_sel2", 2, 1);
    chk_log("resume_sel3", 3, 2);
    i_valid = '0;
    tick(2);

    // Grant 3, then channels 0 and 3 alternate.
    i_valid = 4'b1000;
    tick(1);
    i_valid = '0;
    tick(2);
    clear_log();
    i_valid = 4'b1001;
    tick(6);
    i_valid = '0;
    tick(2);
    chk("alt_count", log_sel.size(), 6);
    for (int i = 0; i < 6; i++) chk_log("alt_sel", i, (i % 2 == 0) ? 0 : 3);

    // Reset while a beat is held and stalled.
    i_valid = 4'b1111; o_ready = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1; i_valid = '0;
    #1;
    chk("post_rst_o_valid", o_valid, 0);
    chk("post_rst_o_sel", o_sel, 0);
    clear_log();
    i_valid = 4'b1111; o_ready = 1'b1;
    tick(3);
    chk_log("post_rst_first_grant", 0, 0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 < 100) i_valid = 4'(1 << (c / 500 % N));
      else i_valid = 4'($urandom);
      for (int k = 0; k < N; k++) i_data[k] = $urandom;
      o_ready = ($urandom_range(0, 3) != 0);
      rst_n   = ($urandom_range(0, 127) != 0);
      tick(1);
    end
    rst_n = 1'b1; i_valid = '0; o_ready = 1'b1;
    tick(3);
    chk("sb_drained", sb_sel.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default DEFAULT_D_W from common_pkg, width of each input and of the output.
REQ-003 SHALL have localparam L = $clog2(N), width of the grant index.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_valid  input  [N-1:0]  per-channel request/valid.
REQ-007 SHALL have port i_data  input  [N-1:0][W-1:0]  per-channel payload.
REQ-008 SHALL have port i_ready  output  [N-1:0]  per-channel accept; at most one bit high per cycle.
REQ-009 SHALL have port o_valid  output  1  output payload valid.
REQ-010 SHALL have port o_data  output  [W-1:0]  selected payload.
REQ-011 SHALL have port o_sel  output  [L-1:0]  index of the channel that sourced o_data.
REQ-012 SHALL have port o_ready  input  1  downstream accept.

Function
REQ-013 SHALL transfer on a channel only when i_valid[k] and i_ready[k] are both high in the same cycle; the output transfers when o_valid and o_ready are both high.
REQ-014 SHALL grant among asserted i_valid bits by round-robin, highest priority at index (last_grant+1) mod N, then ascending with wrap-around.
REQ-015 SHALL update last_grant only on a cycle in which an input transfer completes; without a transfer the priority order is unchanged.
REQ-016 SHALL assert i_ready[g] only for the granted channel g, and only when the stage can accept (see REQ-020/021).
REQ-017 SHALL keep i_ready independent of i_data and combinationally free of any path from i_ready back to i_valid (no valid-depends-on-ready in this block).
REQ-018 SHALL, when no i_valid bit is set, assert no i_ready bit and leave last_grant unchanged.
REQ-019 SHALL, with a single requester k held valid, grant k every eligible cycle (no bubble from round-robin rotation).
REQ-020 SHALL, with ARB_MUX_OUTPUT_REG_EN defined, hold o_valid/o_data/o_sel in an output register: accept a new beat when the register is empty or o_ready is high (load and drain in the same cycle permitted), latency 1 cycle, throughput 1 beat/cycle under continuous o_ready.
REQ-021 SHALL, with ARB_MUX_OUTPUT_REG_EN undefined, be a zero-latency path: o_valid = |i_valid, o_data/o_sel from current grant, i_ready[g] = o_ready.
REQ-022 SHALL hold o_data and o_sel stable while o_valid is high and o_ready is low (registered mode).
REQ-023 SHALL drive o_data to the granted payload bit-exact; no width conversion.

Reset
REQ-024 SHALL, while rst_n is low at a clock edge, set last_grant to N-1 (so channel 0 has first priority), clear the output register valid bit, and set o_data and o_sel to 0.
REQ-025 SHALL, while rst_n is low, drive all i_ready bits low and o_valid low regardless of other inputs.
REQ-026 SHALL discard any beat held in the output register when reset asserts mid-transfer; no beat is replayed after reset.

Configuration
REQ-027 SHALL compile the output register under macro ARB_MUX_OUTPUT_REG_EN: defined gives REQ-020 behaviour, undefined gives REQ-021 behaviour; port list identical in both builds.

Structure
REQ-028 SHALL take DEFAULT_D_W from common_pkg; no new package contents required.
REQ-029 SHALL implement arbitration in one sub-module rr_arbiter (params N; ports clk, rst_n, req[N], advance, grant_oh[N], grant_idx[L]); data mux uses the existing mux module with N and W passed through.
REQ-030 SHALL contain no latches and no multi-cycle or async paths.

Verification (N=4, W=32, both macro builds unless noted)
REQ-031 SHALL check: reset, then i_valid=4'b1111 continuous, o_ready=1 -> o_sel sequence 0,1,2,3,0,... one beat per cycle (registered: first o_valid one cycle after request).
REQ-032 SHALL check: only i_valid[2]=1 for 8 cycles, data 32'hA5A5_0000+cycle -> 8 consecutive beats o_sel=2, data in order, no gaps.
REQ-033 SHALL check (registered build): o_ready=0 for 5 cycles with all inputs valid -> o_valid=1, o_data/o_sel frozen, exactly one i_ready pulse total, then order resumes from next channel when o_ready=1.
REQ-034 SHALL check: i_valid=4'b1001 after grant to 3 -> next grant 0, then 3, alternating.
REQ-035 SHALL check: rst_n low for one cycle while o_valid=1 and o_ready=0 -> next cycle o_valid=0, o_sel=0, first subsequent grant with all valid is channel 0.
REQ-036 SHALL check assertions each cycle: $onehot0(i_ready), i_ready implies i_valid on the same bit, and every input transfer appears exactly once at the output.
